// File: rtl/pic_pkg.sv
// Shared definitions for the PIC product-FIFO drain path.
//   PIC_DATA_W : width of one PIC product word
//   PIC_ACC_W  : default accumulator / dot-product width
//   PIC_CNT_W  : default width of the per-job product count
//   pic_drain_state_t : drain FSM states
package pic_pkg;

  localparam int unsigned PIC_DATA_W = 32;
  localparam int unsigned PIC_ACC_W  = 40;
  localparam int unsigned PIC_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } pic_drain_state_t;

endpackage

// File: rtl/pic_drain_acc.sv
// Drains a programmed number of products from the PIC FIFO, sums them into
// one row dot-product and hands the result to the result writer on a
// valid/ready handshake.
//   clk, reset        : clock, synchronous active-high reset
//   start, len        : job request and product count (sampled in IDLE)
//   fifo_empty        : PIC FIFO empty flag
//   fifo_Out          : PIC FIFO read data, valid the cycle after read
//   read              : FIFO pop strobe (combinational)
//   sum, sum_valid    : job result, held until sum_ready
//   sum_ready         : downstream accepts sum
//   busy              : high whenever a job is in progress
//   overflow          : sticky accumulator carry-out for the current job
module pic_drain_acc
  import pic_pkg::*;
#(
  parameter int unsigned DATA_W = PIC_DATA_W,
  parameter int unsigned ACC_W  = PIC_ACC_W,
  parameter int unsigned CNT_W  = PIC_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_Out,
  output logic              read,
  output logic [ACC_W-1:0]  sum,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic              overflow
);

  pic_drain_state_t state;
  pic_drain_state_t state_nxt;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic [ACC_W:0]   acc_sum;

  // One extra bit captures the carry out of the accumulator.
  assign acc_sum = {1'b0, acc} + (ACC_W+1)'(fifo_Out);

  // Next-state and pop strobe; a pop is only ever issued from FETCH, so at
  // most one product is in flight.
  always_comb begin
    state_nxt = state;
    read      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (!fifo_empty) begin
          read      = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = (remaining == CNT_W'(1)) ? DONE : FETCH;
      end
      DONE: begin
        if (sum_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, accumulator, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      sum_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            overflow  <= 1'b0;
            remaining <= len;
            // An empty job completes immediately with a zero result.
            if (len == '0) begin
              sum <= '0;
            end
          end
        end
        CAPTURE: begin
          acc       <= acc_sum[ACC_W-1:0];
          overflow  <= overflow | acc_sum[ACC_W];
          remaining <= remaining - CNT_W'(1);
          // Last product: publish the final total together with DONE.
          if (remaining == CNT_W'(1)) begin
            sum <= acc_sum[ACC_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_drain_acc.sv
// Bench for pic_drain_acc: directed jobs plus randomized jobs, checked
// against a simple arithmetic model of the expected row total.
module tb_pic_drain_acc;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ACC_W  = 33;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_Out;
  logic              read;
  logic [ACC_W-1:0]  sum;
  logic              sum_valid;
  logic              sum_ready;
  logic              busy;
  logic              overflow;

  logic [DATA_W-1:0] mem [0:255];
  int                wr_ptr;
  int                rd_ptr     = 0;
  int                total_pops = 0;
  int                b2b        = 0;
  logic              read_q     = 1'b0;
  logic              stall;
  logic [DATA_W-1:0] prod_q [$];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pic_drain_acc #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .fifo_empty(fifo_empty),
    .fifo_Out  (fifo_Out),
    .read      (read),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .busy      (busy),
    .overflow  (overflow)
  );

  // FIFO model: data appears the cycle after a pop.
  assign fifo_empty = stall || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (read) begin
      fifo_Out   <= mem[8'(rd_ptr)];
      rd_ptr     <= rd_ptr + 1;
      total_pops <= total_pops + 1;
      if (read_q) b2b <= b2b + 1;
    end
    read_q <= read;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one job of n products taken from prod_q.
  task automatic run_job(input string tag, input int n, input int stall_after,
                         input int stall_cyc, input int rdy_delay, input bit poke);
    longint unsigned  total;
    logic [ACC_W-1:0] exp_sum;
    logic             exp_ovf;
    logic [DATA_W-1:0] v;
    int base, cnt, left;
    bit seen;
    total = 0;
    for (int i = 0; i < n; i++) begin
      v = prod_q.pop_front();
      mem[8'(wr_ptr)] = v;
      wr_ptr++;
      total += 64'(v);
    end
    exp_sum = ACC_W'(total);
    exp_ovf = (total >= (64'd1 << ACC_W));
    base = total_pops;
    left = stall_cyc;
    start = 1'b1;
    len   = CNT_W'(n);
    cnt   = 0;
    seen  = 1'b0;
    while (!seen && cnt < 1000) begin
      @(negedge clk);
      start = 1'b0;
      len   = CNT_W'($urandom);
      cnt++;
      if (sum_valid) begin
        seen = 1'b1;
      end else if (left > 0 && (total_pops - base) == stall_after) begin
        stall = 1'b1;
        left--;
        #1 check({tag, "_stall_read"}, 64'(read), 64'd0);
      end else begin
        stall = 1'b0;
      end
    end
    stall = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (stall_cyc == 0) check({tag, "_latency"}, 64'(cnt), 64'(2 * n + 1));
    check({tag, "_pops"}, 64'(total_pops - base), 64'(n));
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    for (int d = 0; d < rdy_delay; d++) begin
      if (poke && d == 1) begin
        start = 1'b1;
        len   = CNT_W'(3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check({tag, "_hold_sum"}, 64'(sum), 64'(exp_sum));
      check({tag, "_hold_valid"}, 64'(sum_valid), 64'd1);
    end
    start     = 1'b0;
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    check({tag, "_valid_clr"}, 64'(sum_valid), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_sum_kept"}, 64'(sum), 64'(exp_sum));
    repeat (2) @(negedge clk);
    check({tag, "_stay_idle"}, 64'(busy), 64'd0);
    check({tag, "_no_extra_pop"}, 64'(total_pops - base), 64'(n));
  endtask

  initial begin
    int base, guard, n;
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    sum_ready = 1'b0;
    stall     = 1'b0;
    wr_ptr    = 0;
    repeat (2) @(negedge clk);
    check("rst_read", 64'(read), 64'd0);
    check("rst_valid", 64'(sum_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    prod_q = '{32'd10, 32'd20, 32'd30};
    run_job("basic", 3, 0, 0, 0, 1'b0);

    run_job("len0", 0, 0, 0, 0, 1'b0);

    prod_q = '{32'd123, 32'd456};
    run_job("stall", 2, 1, 4, 0, 1'b0);

    prod_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_job("wrap2", 2, 0, 0, 0, 1'b0);

    prod_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_job("ovf3", 3, 0, 0, 5, 1'b1);

    // Abort after the second pop: the in-flight product is dropped.
    mem[8'(wr_ptr)] = 32'd11; wr_ptr++;
    mem[8'(wr_ptr)] = 32'd22; wr_ptr++;
    base  = total_pops;
    start = 1'b1;
    len   = CNT_W'(4);
    guard = 0;
    while ((total_pops - base) < 2 && guard < 100) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
    end
    check("abort_two_pops", 64'(total_pops - base), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    check("abort_read", 64'(read), 64'd0);
    check("abort_valid", 64'(sum_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_pop", 64'(total_pops - base), 64'd2);
    prod_q = '{32'd7};
    run_job("after_abort", 1, 0, 0, 0, 1'b0);

    for (int j = 0; j < 8; j++) begin
      n = int'($urandom_range(0, 6));
      for (int i = 0; i < n; i++) prod_q.push_back($urandom);
      run_job($sformatf("rand%0d", j), n, int'($urandom_range(0, 6)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)));
    end

    check("no_back_to_back", 64'(b2b), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
